id_ex_stage: RTL and testbench

Decode-to-execute pipeline register that feeds the RV64I ALU.
- Captures one decoded instruction per transfer.
- Resolves register-source forwarding.
- Selects ALU operands (rs1/PC, rs2/immediate).
- Presents alu_funct, operand_a and operand_b to the ALU with a valid/ready handshake.
- Refreshes held operands from the bypass network while stalled, so a stalled instruction never executes with stale data.

---
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV64I ALU: captures a decoded instruction, resolves
// forwarding and selects ALU operands. Define ID_EX_FWD_EN to enable bypass forwarding/refresh.
module id_ex_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_alu_funct,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_op_a_sel,
    input  logic                  in_op_b_sel,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_reg_write,
    input  logic                  fwd_mem_we,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]       fwd_mem_data,
    input  logic                  fwd_wb_we,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]       fwd_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_funct,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic [XLEN-1:0]       store_data,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write
);

    // Handshake: a transfer happens on a cycle where valid && ready are both high.
    logic                  r_valid;
    logic [3:0]            r_alu_funct;
    logic [XLEN-1:0]       r_pc;
    logic [REG_ADDR_W-1:0] r_rs1_addr;
    logic [REG_ADDR_W-1:0] r_rs2_addr;
    logic [XLEN-1:0]       r_rs1_val;
    logic [XLEN-1:0]       r_rs2_val;
    logic [XLEN-1:0]       r_imm;
    logic                  r_op_a_sel;
    logic                  r_op_b_sel;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;

    logic                  w_capture;
    logic [REG_ADDR_W-1:0] w_src1_addr;
    logic [REG_ADDR_W-1:0] w_src2_addr;
    logic [XLEN-1:0]       w_src1_base;
    logic [XLEN-1:0]       w_src2_base;
    logic [XLEN-1:0]       w_src1_val;
    logic [XLEN-1:0]       w_src2_val;

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    // One resolver serves both capture (incoming operands) and hold refresh (held operands).
    assign w_src1_addr = w_capture ? in_rs1_addr : r_rs1_addr;
    assign w_src2_addr = w_capture ? in_rs2_addr : r_rs2_addr;
    assign w_src1_base = w_capture ? in_rs1_data : r_rs1_val;
    assign w_src2_base = w_capture ? in_rs2_data : r_rs2_val;

    always_comb begin
        w_src1_val = w_src1_base;
        w_src2_val = w_src2_base;
`ifdef ID_EX_FWD_EN
        // WB first so a matching MEM result overrides it.
        if (fwd_wb_we && (fwd_wb_rd == w_src1_addr)) w_src1_val = fwd_wb_data;
        if (fwd_wb_we && (fwd_wb_rd == w_src2_addr)) w_src2_val = fwd_wb_data;
        if (fwd_mem_we && (fwd_mem_rd == w_src1_addr)) w_src1_val = fwd_mem_data;
        if (fwd_mem_we && (fwd_mem_rd == w_src2_addr)) w_src2_val = fwd_mem_data;
`endif
        if (w_src1_addr == '0) w_src1_val = '0;
        if (w_src2_addr == '0) w_src2_val = '0;
    end

`ifndef ID_EX_FWD_EN
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu_funct <= '0;
            r_pc        <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_op_a_sel  <= 1'b0;
            r_op_b_sel  <= 1'b0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_alu_funct <= in_alu_funct;
            r_pc        <= in_pc;
            r_rs1_addr  <= in_rs1_addr;
            r_rs2_addr  <= in_rs2_addr;
            r_rs1_val   <= w_src1_val;
            r_rs2_val   <= w_src2_val;
            r_imm       <= in_imm;
            r_op_a_sel  <= in_op_a_sel;
            r_op_b_sel  <= in_op_b_sel;
            r_rd_addr   <= in_rd_addr;
            r_reg_write <= in_reg_write;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            r_rs1_val <= w_src1_val;
            r_rs2_val <= w_src2_val;
        end
    end

    assign out_valid     = r_valid;
    assign alu_funct     = r_alu_funct;
    assign operand_a     = r_op_a_sel ? r_pc : r_rs1_val;
    assign operand_b     = r_op_b_sel ? r_imm : r_rs2_val;
    assign store_data    = r_rs2_val;
    assign out_pc        = r_pc;
    assign out_rd_addr   = r_rd_addr;
    assign out_reg_write = r_reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model plus directed literal checks,
// followed by randomized traffic. Follows ID_EX_FWD_EN the same way as the design.
module tb_id_ex_stage;

    localparam int XLEN = 64;
    localparam int AW   = 5;
`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      in_alu_funct = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [AW-1:0]   in_rs1_addr = '0;
    logic [AW-1:0]   in_rs2_addr = '0;
    logic [XLEN-1:0] in_rs1_data = '0;
    logic [XLEN-1:0] in_rs2_data = '0;
    logic [XLEN-1:0] in_imm = '0;
    logic            in_op_a_sel = 1'b0;
    logic            in_op_b_sel = 1'b0;
    logic [AW-1:0]   in_rd_addr = '0;
    logic            in_reg_write = 1'b0;
    logic            fwd_mem_we = 1'b0;
    logic [AW-1:0]   fwd_mem_rd = '0;
    logic [XLEN-1:0] fwd_mem_data = '0;
    logic            fwd_wb_we = 1'b0;
    logic [AW-1:0]   fwd_wb_rd = '0;
    logic [XLEN-1:0] fwd_wb_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [3:0]      alu_funct;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] out_pc;
    logic [AW-1:0]   out_rd_addr;
    logic            out_reg_write;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_funct(in_alu_funct), .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_op_a_sel(in_op_a_sel), .in_op_b_sel(in_op_b_sel),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_funct(alu_funct),
        .operand_a(operand_a), .operand_b(operand_b), .store_data(store_data),
        .out_pc(out_pc), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
    );

    // Clock/reset
    always #5 clk = ~clk;

    // Reference model: the instruction currently held, with operand values as the ALU should see them.
    bit              m_valid;
    logic [3:0]      m_funct;
    logic [XLEN-1:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [AW-1:0]   m_a1, m_a2, m_rd;
    bit              m_asel, m_bsel, m_we;

    function automatic logic [XLEN-1:0] bypass(input logic [AW-1:0] a, input logic [XLEN-1:0] dflt);
        if (a == 0) return '0;
        if (FWD && fwd_mem_we && fwd_mem_rd == a) return fwd_mem_data;
        if (FWD && fwd_wb_we && fwd_wb_rd == a) return fwd_wb_data;
        return dflt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_funct = 0; m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0;
            m_a1 = 0; m_a2 = 0; m_rd = 0; m_asel = 0; m_bsel = 0; m_we = 0;
        end else if (flush) begin
            m_valid = 0; m_we = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1; m_funct = in_alu_funct; m_pc = in_pc; m_imm = in_imm;
            m_a1 = in_rs1_addr; m_a2 = in_rs2_addr; m_rd = in_rd_addr;
            m_rs1 = bypass(in_rs1_addr, in_rs1_data); m_rs2 = bypass(in_rs2_addr, in_rs2_data);
            m_asel = in_op_a_sel; m_bsel = in_op_b_sel; m_we = in_reg_write;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end else if (m_valid) begin
            m_rs1 = bypass(m_a1, m_rs1);
            m_rs2 = bypass(m_a2, m_rs2);
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on the falling edge, every cycle.
    always @(negedge clk) begin
        chk("cmp_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("cmp_in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
        if (m_valid) begin
            chk("cmp_alu_funct", {60'd0, alu_funct}, {60'd0, m_funct});
            chk("cmp_operand_a", operand_a, m_asel ? m_pc : m_rs1);
            chk("cmp_operand_b", operand_b, m_bsel ? m_imm : m_rs2);
            chk("cmp_store_data", store_data, m_rs2);
            chk("cmp_out_pc", out_pc, m_pc);
            chk("cmp_rd_addr", {59'd0, out_rd_addr}, {59'd0, m_rd});
            chk("cmp_reg_write", {63'd0, out_reg_write}, {63'd0, m_we});
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] f, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                             input logic [AW-1:0] a2, input logic [XLEN-1:0] d2);
        in_valid = 1; in_alu_funct = f;
        in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
        in_op_a_sel = 0; in_op_b_sel = 0; in_rd_addr = 5'd9; in_reg_write = 1;
    endtask

    task automatic fwd_off();
        fwd_mem_we = 0; fwd_wb_we = 0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_operand_a", operand_a, 64'd0);
        chk("reset_operand_b", operand_b, 64'd0);
        chk("reset_store_data", store_data, 64'd0);
        chk("reset_out_pc", out_pc, 64'd0);
        chk("reset_reg_write", {63'd0, out_reg_write}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1;
        step();

        // ADD capture
        out_ready = 1;
        set_instr(4'd0, 5'd1, 64'd5, 5'd2, 64'd7);
        step();
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_funct", {60'd0, alu_funct}, 64'd0);
        chk("add_operand_a", operand_a, 64'd5);
        chk("add_operand_b", operand_b, 64'd7);

        // MEM beats WB; WB alone; x0 always zero
        set_instr(4'd0, 5'd3, 64'h55, 5'd2, 64'd7);
        fwd_mem_we = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 64'h100;
        fwd_wb_we = 1; fwd_wb_rd = 5'd3; fwd_wb_data = 64'h200;
        step();
        chk("fwd_mem_prio", operand_a, FWD ? 64'h100 : 64'h55);
        fwd_mem_we = 0;
        step();
        chk("fwd_wb_only", operand_a, FWD ? 64'h200 : 64'h55);
        set_instr(4'd0, 5'd0, 64'h77, 5'd2, 64'd7);
        fwd_mem_we = 1; fwd_mem_rd = 5'd0; fwd_wb_we = 1; fwd_wb_rd = 5'd0;
        step();
        chk("fwd_x0_zero", operand_a, 64'd0);
        fwd_off();

        // Stall refresh
        set_instr(4'd0, 5'd1, 64'd5, 5'd4, 64'd1);
        step();
        out_ready = 0;
        set_instr(4'd1, 5'd1, 64'd9, 5'd2, 64'd9);
        step();
        chk("stall_in_ready_1", {63'd0, in_ready}, 64'd0);
        chk("stall_store_1", store_data, 64'd1);
        fwd_wb_we = 1; fwd_wb_rd = 5'd4; fwd_wb_data = 64'hDEAD;
        step();
        chk("stall_store_2", store_data, FWD ? 64'hDEAD : 64'd1);
        chk("stall_operand_b_2", operand_b, FWD ? 64'hDEAD : 64'd1);
        fwd_off();
        step();
        chk("stall_store_3", store_data, FWD ? 64'hDEAD : 64'd1);
        chk("stall_in_ready_3", {63'd0, in_ready}, 64'd0);
        in_valid = 0; out_ready = 1;
        step();

        // PC / immediate select
        set_instr(4'd0, 5'd1, 64'd5, 5'd2, 64'd7);
        in_op_a_sel = 1; in_pc = 64'h8000_0000; in_op_b_sel = 1; in_imm = -64'sd4;
        step();
        chk("sel_operand_a", operand_a, 64'h8000_0000);
        chk("sel_operand_b", operand_b, 64'hFFFF_FFFF_FFFF_FFFC);

        // Back-to-back streaming
        for (int i = 0; i < 4; i++) begin
            set_instr(4'(i + 2), 5'd1, 64'(i), 5'd2, 64'd7);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            step();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_funct", {60'd0, alu_funct}, 64'(i + 2));
        end
        in_valid = 0;
        step();
        chk("stream_drain", {63'd0, out_valid}, 64'd0);

        // Flush with simultaneous capture
        set_instr(4'd0, 5'd1, 64'd5, 5'd2, 64'd7);
        step();
        flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_reg_write", {63'd0, out_reg_write}, 64'd0);

        // Asynchronous reset while holding
        set_instr(4'd0, 5'd1, 64'd5, 5'd2, 64'd7);
        out_ready = 0;
        step();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_operand_a", operand_a, 64'd0);
        step();
        rst_n = 1;
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 9) < 6);
            flush        = ($urandom_range(0, 15) == 0);
            in_alu_funct = 4'($urandom);
            in_pc        = {$urandom, $urandom};
            in_rs1_addr  = 5'($urandom_range(0, 3));
            in_rs2_addr  = 5'($urandom_range(0, 3));
            in_rs1_data  = {$urandom, $urandom};
            in_rs2_data  = {$urandom, $urandom};
            in_imm       = {$urandom, $urandom};
            in_op_a_sel  = 1'($urandom);
            in_op_b_sel  = 1'($urandom);
            in_rd_addr   = 5'($urandom);
            in_reg_write = 1'($urandom);
            fwd_mem_we   = 1'($urandom);
            fwd_mem_rd   = 5'($urandom_range(0, 3));
            fwd_mem_data = {$urandom, $urandom};
            fwd_wb_we    = 1'($urandom);
            fwd_wb_rd    = 5'($urandom_range(0, 3));
            fwd_wb_data  = {$urandom, $urandom};
            step();
        end
        in_valid = 0; flush = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
